// File: rtl/res4bit_pkg.sv
// Shared constants for the registered 4-bit subtractor: width, reset value and saturation limits.
// The optional clamp on signed overflow is enabled by defining RES4BIT_SATURATE_EN.
package res4bit_pkg;

   localparam int WIDTH = 4;

   localparam logic [3:0] RESULT_RST = 4'b0000;
   localparam logic [3:0] SAT_POS    = 4'b0111;
   localparam logic [3:0] SAT_NEG    = 4'b1000;

endpackage

// File: rtl/res_4bit_ripple_adder4.sv
// Purely combinational 4-bit ripple-carry adder made of four full-adder cells.
// It also exposes the carry into the MSB so the caller can derive signed overflow.
module ripple_adder4
   import res4bit_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       c3,
   output logic       c4
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : gFullAdder
      assign s[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c3 = carry[WIDTH-1];
   assign c4 = carry[WIDTH];

endmodule

// File: rtl/res_4bit.sv
// Registered 4-bit two's-complement subtractor: result = n1 + ~n2 + 1, with carry-out and overflow.
// Define RES4BIT_SATURATE_EN to clamp result to 0111/1000 on signed overflow.
module res_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] n1,
   input  logic [WIDTH-1:0] n2,
   output logic [WIDTH-1:0] result,
   output logic             Co,
   output logic             Overflow
);

   import res4bit_pkg::*;

   logic [WIDTH-1:0] n2Inv;
   logic [WIDTH-1:0] sumRaw;
   logic             carryMsbIn;
   logic             carryOut;
   logic             overflowRaw;

   logic [WIDTH-1:0] result_d, result_q;
   logic             co_d, co_q;
   logic             overflow_d, overflow_q;

   // Subtraction reuses the adder: the +1 of the negation rides in as carry-in.
   assign n2Inv = ~n2;

   ripple_adder4 uAdder (
      .a   (n1),
      .b   (n2Inv),
      .cin (1'b1),
      .s   (sumRaw),
      .c3  (carryMsbIn),
      .c4  (carryOut)
   );

   assign overflowRaw = carryOut ^ carryMsbIn;

   always_comb begin
      result_d   = sumRaw;
      co_d       = carryOut;
      overflow_d = overflowRaw;
`ifdef RES4BIT_SATURATE_EN
      if (overflowRaw) begin
         result_d = n1[WIDTH-1] ? SAT_NEG : SAT_POS;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q   <= RESULT_RST;
         co_q       <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         result_q   <= result_d;
         co_q       <= co_d;
         overflow_q <= overflow_d;
      end
   end

   assign result   = result_q;
   assign Co       = co_q;
   assign Overflow = overflow_q;

endmodule

// File: tb/tb_res_4bit.sv
// Scoreboard bench for res_4bit: stimulus pushes expected responses, a monitor pops and compares.
// Expected results follow RES4BIT_SATURATE_EN the same way the design does.
module tb_res_4bit;

   logic       clk;
   logic       rst;
   logic [3:0] n1;
   logic [3:0] n2;
   logic [3:0] result;
   logic       Co;
   logic       Overflow;

   typedef struct {
      logic [3:0] res;
      logic       co;
      logic       ov;
      string      name;
   } expect_t;

   expect_t sbQ[$];
   int checks   = 0;
   int failures = 0;

   res_4bit #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .n1       (n1),
      .n2       (n2),
      .result   (result),
      .Co       (Co),
      .Overflow (Overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic expect_t refModel(input logic [3:0] a, input logic [3:0] b);
      expect_t e;
      int      sa;
      int      sb;
      int      diff;
      sa     = a[3] ? int'(a) - 16 : int'(a);
      sb     = b[3] ? int'(b) - 16 : int'(b);
      diff   = sa - sb;
      e.res  = 4'((int'(a) - int'(b) + 16) % 16);
      e.co   = (a >= b);
      e.ov   = (diff > 7) || (diff < -8);
`ifdef RES4BIT_SATURATE_EN
      if (e.ov) e.res = a[3] ? 4'b1000 : 4'b0111;
`endif
      e.name = $sformatf("sweep n1=%b n2=%b", a, b);
      return e;
   endfunction

   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] expRes, input logic expCo,
                                input logic expOv, input string name);
      expect_t e;
      @(negedge clk);
      n1     = a;
      n2     = b;
      e.res  = expRes;
      e.co   = expCo;
      e.ov   = expOv;
      e.name = name;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input expect_t e);
      checks++;
      if (result !== e.res || Co !== e.co || Overflow !== e.ov) begin
         failures++;
         $display("[TB] FAIL %s: got result=%b Co=%b Ov=%b, expected result=%b Co=%b Ov=%b",
                  e.name, result, Co, Overflow, e.res, e.co, e.ov);
      end
   endtask

   task automatic checkReset(input string name);
      checks++;
      if (result !== 4'b0000 || Co !== 1'b0 || Overflow !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s: got result=%b Co=%b Ov=%b, expected result=0000 Co=0 Ov=0",
                  name, result, Co, Overflow);
      end
   endtask

   task automatic drainQueue();
      int budget = 20;
      while (sbQ.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      #2;
      if (sbQ.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: got %0d pending entries, expected 0", sbQ.size());
         sbQ.delete();
      end
   endtask

   // Monitor: every clocked output corresponds to the oldest queued expectation.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      logic [3:0] satPos;
      logic [3:0] satNeg;
`ifdef RES4BIT_SATURATE_EN
      satPos = 4'b0111;
      satNeg = 4'b1000;
`else
      satPos = 4'b1000;
      satNeg = 4'b0111;
`endif
      rst = 1'b1;
      n1  = 4'b0110;
      n2  = 4'b0001;
      #3;
      checkReset("reset_state");
      repeat (2) @(posedge clk);
      #1;
      checkReset("reset_holds_over_edges");
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, "first_after_reset");
      applyStimulus(4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, "borrow");
      applyStimulus(4'b1000, 4'b0001, satPos ^ 4'b1111, 1'b1, 1'b1, "neg_overflow");
      applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "zero_zero");
      applyStimulus(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0, "equal_operands");
      applyStimulus(4'b1001, 4'b0000, 4'b1001, 1'b1, 1'b0, "subtract_zero");
      applyStimulus(4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0, "wrap_minus_one");
      applyStimulus(4'b0111, 4'b1111, satPos, 1'b0, 1'b1, "pos_overflow");
      drainQueue();

      // Mid-stream reset with nonzero outputs and an operand pair in flight.
      @(negedge clk);
      n1 = 4'b0101;
      n2 = 4'b0011;
      #2;
      rst = 1'b1;
      #1;
      checkReset("async_reset_immediate");
      @(posedge clk);
      #1;
      checkReset("reset_ignores_edge");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, "after_midstream_reset");
      applyStimulus(4'b1000, 4'b0001, satNeg, 1'b1, 1'b1, "neg_overflow_again");
      drainQueue();

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            expect_t e;
            e = refModel(4'(a), 4'(b));
            applyStimulus(4'(a), 4'(b), e.res, e.co, e.ov, e.name);
         end
      end
      drainQueue();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
